// File: rtl/palette_pkg.sv
// Shared types and reset-palette definition for the sprite palette bank.
package palette_pkg;

    localparam int PKG_COLOR_W = 4;

    typedef struct packed {
        logic [PKG_COLOR_W-1:0] red;
        logic [PKG_COLOR_W-1:0] green;
        logic [PKG_COLOR_W-1:0] blue;
    } rgb_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_e;

    // Channels are either all-zero or all-one, so callers may widen bit 0 to any COLOR_W.
    function automatic rgb_t default_entry(input int unsigned index);
        rgb_t e;
        case (index)
            32'd0:   e = '{red: 4'hF, green: 4'hF, blue: 4'hF};
            32'd1:   e = '{red: 4'h0, green: 4'h0, blue: 4'h0};
            32'd2:   e = '{red: 4'hF, green: 4'h0, blue: 4'h0};
            default: e = '{red: 4'h0, green: 4'h0, blue: 4'h0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sprite_palette_bank_if.sv
// Pixel lookup, palette write, frame control and colour output bundle.
interface sprite_palette_bank_if #(
    parameter int INDEX_W   = 4,
    parameter int COLOR_W   = 4,
    parameter int NUM_BANKS = 4
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                   frame_start;
    logic [BANK_W-1:0]      bank_sel;
    logic                   wr_en;
    logic [BANK_W-1:0]      wr_bank;
    logic [INDEX_W-1:0]     wr_index;
    logic [3*COLOR_W-1:0]   wr_data;
    logic                   pix_valid;
    logic [INDEX_W-1:0]     pix_index;
    logic                   flash_req;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   out_valid;
    logic                   transparent;
    logic                   flashing;
    logic [BANK_W-1:0]      active_bank;

    modport master (
        output frame_start, bank_sel, wr_en, wr_bank, wr_index, wr_data,
               pix_valid, pix_index, flash_req,
        input  red, green, blue, out_valid, transparent, flashing, active_bank
    );

    modport slave (
        input  frame_start, bank_sel, wr_en, wr_bank, wr_index, wr_data,
               pix_valid, pix_index, flash_req,
        output red, green, blue, out_valid, transparent, flashing, active_bank
    );

endinterface

// File: rtl/palette_flash_ctrl.sv
// Frame-counted damage-flash FSM: phase toggles every frame while flashing.
module palette_flash_ctrl
    import palette_pkg::*;
#(
    parameter int FLASH_FRAMES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic flash_req,
    output logic phase,
    output logic flashing
);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    flash_state_e  state_r, state_s;
    logic [FW-1:0] frames_left_r, frames_left_s;
    logic          phase_r, phase_s;

    // State, frame counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            frames_left_r <= {FW{1'b0}};
            phase_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            frames_left_r <= frames_left_s;
            phase_r       <= phase_s;
        end
    end

    // Next state; a restart request outranks the frame decrement.
    always_comb begin
        state_s       = state_r;
        frames_left_s = frames_left_r;
        phase_s       = phase_r;
        case (state_r)
            IDLE: begin
                if (flash_req) begin
                    state_s       = FLASH;
                    frames_left_s = FW'(FLASH_FRAMES);
                    phase_s       = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            FLASH: begin
                if (flash_req) begin
                    frames_left_s = FW'(FLASH_FRAMES);
                    phase_s       = 1'b1;
                end else if (frame_start) begin
                    if (frames_left_r == FW'(1)) begin
                        state_s       = IDLE;
                        frames_left_s = {FW{1'b0}};
                        phase_s       = 1'b0;
                    end else begin
                        frames_left_s = frames_left_r - FW'(1);
                        phase_s       = ~phase_r;
                    end
                end else begin
                    state_s = FLASH;
                end
            end
            default: begin
                state_s       = IDLE;
                frames_left_s = {FW{1'b0}};
                phase_s       = 1'b0;
            end
        endcase
    end

    assign phase    = phase_r;
    assign flashing = (state_r == FLASH);

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-bank writable palette with tear-free bank commit and a 2-stage lookup pipeline.
module sprite_palette_bank
    import palette_pkg::*;
#(
    parameter int INDEX_W      = 4,
    parameter int COLOR_W      = 4,
    parameter int NUM_BANKS    = 4,
    parameter int TRANSP_INDEX = 0,
    parameter int FLASH_FRAMES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sprite_palette_bank_if.slave bus
);
    localparam int ENTRIES = 2 ** INDEX_W;
    localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int RGB_W   = 3 * COLOR_W;

    logic [RGB_W-1:0]  palette_r [NUM_BANKS][ENTRIES];
    logic [BANK_W-1:0] active_bank_r;
    logic [RGB_W-1:0]  s1_color_r;
    logic              s1_valid_r;
    logic              s1_transp_r;
    logic [RGB_W-1:0]  rgb_r;
    logic              out_valid_r;
    logic              transparent_r;
    logic              phase_s;
    logic              flashing_s;

    function automatic logic [RGB_W-1:0] default_color(input int unsigned idx);
        rgb_t e;
        e = default_entry(idx);
        return {{COLOR_W{e.red[0]}}, {COLOR_W{e.green[0]}}, {COLOR_W{e.blue[0]}}};
    endfunction

    // Palette storage: reset to defaults, out-of-range bank writes dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    palette_r[b][i] <= default_color(i);
                end
            end
        end else if (bus.wr_en && (int'(bus.wr_bank) < NUM_BANKS)) begin
            palette_r[bus.wr_bank][bus.wr_index] <= bus.wr_data;
        end
    end

    // Bank register only moves at frame boundaries so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_bank_r <= {BANK_W{1'b0}};
        end else if (bus.frame_start && (int'(bus.bank_sel) < NUM_BANKS)) begin
            active_bank_r <= bus.bank_sel;
        end
    end

    // Stage 1: fetch entry; reads the pre-write value on a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_color_r  <= {RGB_W{1'b0}};
            s1_valid_r  <= 1'b0;
            s1_transp_r <= 1'b0;
        end else begin
            s1_color_r  <= palette_r[active_bank_r][bus.pix_index];
            s1_valid_r  <= bus.pix_valid;
            s1_transp_r <= (bus.pix_index == INDEX_W'(TRANSP_INDEX));
        end
    end

    // Stage 2: flash override on opaque pixels, blank colour when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r         <= {RGB_W{1'b0}};
            out_valid_r   <= 1'b0;
            transparent_r <= 1'b0;
        end else if (s1_valid_r) begin
            rgb_r         <= (phase_s && !s1_transp_r) ? {RGB_W{1'b1}} : s1_color_r;
            out_valid_r   <= 1'b1;
            transparent_r <= s1_transp_r;
        end else begin
            rgb_r         <= {RGB_W{1'b0}};
            out_valid_r   <= 1'b0;
            transparent_r <= 1'b0;
        end
    end

    palette_flash_ctrl #(
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_flash (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (bus.frame_start),
        .flash_req   (bus.flash_req),
        .phase       (phase_s),
        .flashing    (flashing_s)
    );

    assign bus.red         = rgb_r[RGB_W-1 -: COLOR_W];
    assign bus.green       = rgb_r[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue        = rgb_r[COLOR_W-1:0];
    assign bus.out_valid   = out_valid_r;
    assign bus.transparent = transparent_r;
    assign bus.flashing    = flashing_s;
    assign bus.active_bank = active_bank_r;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench: table-driven lookups plus hand sequences for writes, banks, flash and reset.
module tb_sprite_palette_bank;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sprite_palette_bank_if #(.INDEX_W(4), .COLOR_W(4), .NUM_BANKS(3)) bus ();

    sprite_palette_bank #(
        .INDEX_W(4), .COLOR_W(4), .NUM_BANKS(3), .TRANSP_INDEX(0), .FLASH_FRAMES(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [11:0] rgb;
        logic        transp;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [11:0] rgb_now();
        return {bus.red, bus.green, bus.blue};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [3:0] idx);
        bus.pix_valid = 1'b1;
        bus.pix_index = idx;
        step();
        bus.pix_valid = 1'b0;
        step();
    endtask

    task automatic write(input logic [1:0] bank, input logic [3:0] idx, input logic [11:0] data);
        bus.wr_en    = 1'b1;
        bus.wr_bank  = bank;
        bus.wr_index = idx;
        bus.wr_data  = data;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic frame(input logic [1:0] sel);
        bus.bank_sel    = sel;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{idx: 4'd0, rgb: 12'hFFF, transp: 1'b1};
        vecs[1] = '{idx: 4'd1, rgb: 12'h000, transp: 1'b0};
        vecs[2] = '{idx: 4'd2, rgb: 12'hF00, transp: 1'b0};
        vecs[3] = '{idx: 4'd3, rgb: 12'h000, transp: 1'b0};

        bus.frame_start = 1'b0; bus.bank_sel = 2'd0; bus.wr_en = 1'b0; bus.wr_bank = 2'd0;
        bus.wr_index = 4'd0; bus.wr_data = 12'h000; bus.pix_valid = 1'b0; bus.pix_index = 4'd0;
        bus.flash_req = 1'b0;
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        step();
        check("reset_rgb", 32'(rgb_now()), 32'h000);
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_bank", 32'(bus.active_bank), 32'd0);
        check("reset_flashing", 32'(bus.flashing), 32'd0);

        // Back-to-back default lookups; outputs lag the index by two edges.
        for (int i = 0; i <= 4; i++) begin
            bus.pix_valid = (i < 4);
            bus.pix_index = (i < 4) ? vecs[i].idx : 4'd0;
            step();
            if (i >= 1) begin
                check("tbl_rgb", 32'(rgb_now()), 32'(vecs[i-1].rgb));
                check("tbl_transp", 32'(bus.transparent), 32'(vecs[i-1].transp));
                check("tbl_valid", 32'(bus.out_valid), 32'd1);
            end
        end
        step();
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        check("idle_rgb", 32'(rgb_now()), 32'h000);

        write(2'd1, 4'd5, 12'h3A7);
        write(2'd3, 4'd5, 12'h555);
        bus.bank_sel = 2'd1;
        lookup(4'd5);
        check("pre_commit_rgb", 32'(rgb_now()), 32'h000);
        check("pre_commit_bank", 32'(bus.active_bank), 32'd0);
        frame(2'd1);
        check("commit_bank", 32'(bus.active_bank), 32'd1);
        lookup(4'd5);
        check("commit_rgb", 32'(rgb_now()), 32'h3A7);

        // Same-cycle write and read of one entry returns the old value.
        bus.wr_en = 1'b1; bus.wr_bank = 2'd1; bus.wr_index = 4'd2; bus.wr_data = 12'h0F0;
        bus.pix_valid = 1'b1; bus.pix_index = 4'd2;
        step();
        bus.wr_en = 1'b0;
        step();
        bus.pix_valid = 1'b0;
        check("rdw_old", 32'(rgb_now()), 32'hF00);
        step();
        check("rdw_new", 32'(rgb_now()), 32'h0F0);

        frame(2'd0);
        check("bank_back", 32'(bus.active_bank), 32'd0);
        frame(2'd3);
        check("bank_oob_ignored", 32'(bus.active_bank), 32'd0);

        write(2'd0, 4'd0, 12'h123);
        bus.flash_req = 1'b1;
        step();
        bus.flash_req = 1'b0;
        check("flash_on", 32'(bus.flashing), 32'd1);
        lookup(4'd2);
        check("flash_ph0", 32'(rgb_now()), 32'hFFF);
        lookup(4'd0);
        check("flash_transp_rgb", 32'(rgb_now()), 32'h123);
        check("flash_transp", 32'(bus.transparent), 32'd1);
        for (int f = 1; f <= 4; f++) begin
            check("flash_pre_frame", 32'(bus.flashing), 32'd1);
            frame(2'd0);
            lookup(4'd2);
            check("flash_alt", 32'(rgb_now()), (f == 2) ? 32'hFFF : 32'hF00);
        end
        check("flash_off", 32'(bus.flashing), 32'd0);
        lookup(4'd2);
        check("flash_steady", 32'(rgb_now()), 32'hF00);

        // Restart coincident with frame_start: reload wins, decrement skipped.
        bus.flash_req = 1'b1;
        step();
        bus.flash_req = 1'b0;
        frame(2'd0);
        frame(2'd0);
        bus.flash_req = 1'b1;
        frame(2'd0);
        bus.flash_req = 1'b0;
        lookup(4'd2);
        check("restart_phase", 32'(rgb_now()), 32'hFFF);
        for (int f = 1; f <= 3; f++) begin
            frame(2'd0);
            check("restart_still_on", 32'(bus.flashing), 32'd1);
        end
        frame(2'd0);
        check("restart_off", 32'(bus.flashing), 32'd0);

        write(2'd1, 4'd7, 12'hABC);
        frame(2'd1);
        bus.flash_req = 1'b1;
        step();
        bus.flash_req = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_index = 4'd7;
        step();
        step();
        check("pre_reset_rgb", 32'(rgb_now()), 32'hFFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rgb", 32'(rgb_now()), 32'h000);
        check("async_valid", 32'(bus.out_valid), 32'd0);
        check("async_bank", 32'(bus.active_bank), 32'd0);
        check("async_flashing", 32'(bus.flashing), 32'd0);
        bus.pix_valid = 1'b0;
        #10 rst_n = 1'b1;
        step();
        check("post_reset_valid", 32'(bus.out_valid), 32'd0);
        lookup(4'd0);
        check("revert_b0_i0", 32'(rgb_now()), 32'hFFF);
        frame(2'd1);
        lookup(4'd7);
        check("revert_b1_i7", 32'(rgb_now()), 32'h000);
        lookup(4'd2);
        check("revert_b1_i2", 32'(rgb_now()), 32'hF00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_palette_bank.md
# sprite_palette_bank

Multi-bank, runtime-writable colour palette for sprite and tile rendering. It sits between a sprite ROM's index output and the VGA colour mux: it maps a pixel index to a 12-bit RGB colour through a 2-stage pipeline. It adds per-frame bank switching without tearing, CPU/game-logic palette writes, a transparency flag, and a frame-counted "damage flash" effect.

## Interface
- INDEX_W, default 4: pixel index width; 2**INDEX_W entries per bank.
- COLOR_W, default 4: bits per colour channel.
- NUM_BANKS, default 4: number of palette banks (≥1).
- TRANSP_INDEX, default 0: index reported as transparent.
- FLASH_FRAMES, default 16: frames a flash lasts.
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- bank_sel  in  $clog2(NUM_BANKS)  requested bank, committed at frame_start
- wr_en  in  1  palette write strobe
- wr_bank  in  $clog2(NUM_BANKS)  write bank
- wr_index  in  INDEX_W  write entry
- wr_data  in  3*COLOR_W  {R,G,B} write value
- pix_valid  in  1  lookup request
- pix_index  in  INDEX_W  lookup index
- flash_req  in  1  one-cycle pulse, start or restart a flash
- red, green, blue  out  COLOR_W each  looked-up colour
- out_valid  out  1  colour outputs valid
- transparent  out  1  looked-up index == TRANSP_INDEX
- flashing  out  1  flash effect active
- active_bank  out  $clog2(NUM_BANKS)  bank currently used for lookups

## Operation
- Palette storage is flops, NUM_BANKS × 2**INDEX_W × 3*COLOR_W. Every bank initialises on reset to the default palette: entry 0 = F,F,F; entry 1 = 0,0,0; entry 2 = F,0,0; all others 0,0,0. At widths other than 4, "F" means all ones.
- Write: when wr_en is high at an edge, the entry is updated at that edge. A write with wr_bank ≥ NUM_BANKS is ignored.
- Bank commit: active_bank <= bank_sel only on a frame_start cycle. A bank_sel value ≥ NUM_BANKS is ignored, and active_bank holds its value.
- Lookup stage 1 registers the palette entry [active_bank][pix_index], pix_valid, and (pix_index == TRANSP_INDEX).
- Lookup stage 2 registers the outputs. If the flash phase is 1 and the pixel is not transparent, the RGB outputs are forced to all ones; otherwise they pass the stage-1 colour unchanged.
- Flash FSM:
  - States are IDLE and FLASH. The FSM keeps a frames_left counter (width $clog2(FLASH_FRAMES+1)) and a phase bit.
  - IDLE → FLASH on flash_req. Loads frames_left=FLASH_FRAMES and phase=1.
  - In FLASH, each frame_start decrements frames_left and toggles phase. When frames_left goes 1→0, the FSM enters IDLE with phase=0.
  - flash_req in FLASH reloads the counter and sets phase=1 (restart).
  - flashing = (state == FLASH).

## Timing
- Lookup latency is 2 cycles. pix_index sampled at edge N appears on red/green/blue/transparent/out_valid after edge N+1.
- out_valid follows pix_valid delayed by 2 cycles. When out_valid is 0, the RGB outputs are 0.
- Read-during-write to the same entry in the same cycle returns the old value. The new value is visible to an index sampled at the next edge.
- A bank change committed at edge N applies to indices sampled at edge N+1 and later. Pixels already in the pipeline keep the old bank.
- The flash phase used is the value present when a pixel enters stage 2.
- frame_start and flash_req in the same cycle: flash_req wins (reload, phase=1), and the decrement is skipped.
- frame_start and a bank_sel change in the same cycle: the new bank_sel is committed.
- Reset is asynchronous. All outputs go to 0 (active_bank=0, flashing=0), the FSM goes to IDLE, and all banks reload the default palette. Assertion mid-frame discards the pipeline contents.

## Structure
- palette_pkg holds:
  - rgb_t, a packed struct {red, green, blue} at COLOR_W.
  - flash_state_e, with values IDLE and FLASH.
  - function default_entry(index), which returns the reset palette.
- Sub-module palette_flash_ctrl contains the FSM, frames_left and phase. Its inputs are frame_start and flash_req; its outputs are phase and flashing.
- The top level holds the storage, write port, bank register and 2-stage pipeline.

## Test plan
- Reset, then pix_index 0,1,2,3 on consecutive cycles → outputs FFF, 000, F00, 000 starting 2 cycles later; transparent=1 only for index 0.
- Write bank 1, index 5 = 0x3A7, with bank_sel=1 and no frame_start → lookups of 5 still return 000. Pulse frame_start → the next lookup of 5 returns R=3,G=A,B=7, and active_bank=1.
- Same-cycle write and lookup of entry 2 (new value 0x0F0) → the old value F00 is returned. A lookup one cycle later returns 0F0.
- Pulse flash_req with FLASH_FRAMES=4, stream index 2 and index 0, and pulse frame_start 4 times:
  - Index 2 alternates FFF / F00 / FFF / F00; index 0 keeps its own colour and transparent=1.
  - flashing drops on the 4th frame_start, after which index 2 returns F00 steadily.
- flash_req coincident with frame_start mid-flash → frames_left reloads to FLASH_FRAMES and phase=1.
- Assert rst_n mid-stream after writes and a bank switch → all outputs 0 immediately, active_bank=0, and the written entries revert to their defaults.
